// File: rtl/seg_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl_if
// Bundles the signals between the counter datapath / display pins and the
// seg_scan_ctrl scan scheduler.
//   en         : scan enable (low holds the scheduler in its reset state)
//   cathod     : polarity select, 0 = common-anode, 1 = common-cathode
//   lz_en      : leading-zero blanking enable
//   digits     : packed 4-bit digit values, digit k at [4k+3:4k]
//   seg        : physical segment drive {g,f,e,d,c,b,a}
//   an         : physical digit selects, bit k selects digit k
//   frame_done : one-cycle pulse at the end of the last digit's slot
// master = the side that supplies digits/controls, slave = the scheduler.
// ---------------------------------------------------------------------------
interface seg_scan_ctrl_if #(
    parameter int N_DIGITS = 2
);
    logic                  en;
    logic                  cathod;
    logic                  lz_en;
    logic [4*N_DIGITS-1:0] digits;
    logic [6:0]            seg;
    logic [N_DIGITS-1:0]   an;
    logic                  frame_done;

    modport master (
        output en, cathod, lz_en, digits,
        input  seg, an, frame_done
    );

    modport slave (
        input  en, cathod, lz_en, digits,
        output seg, an, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexes one 7-segment bus over N_DIGITS digit selects. Each digit
// gets an ON slot of ON_TICKS ticks preceded by BLANK_TICKS ticks of all-off
// dead-time; a tick is PRESCALE clock cycles. Digit values are snapshotted
// when a slot starts, hex-decoded, optionally leading-zero blanked, and
// driven with selectable polarity.
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset, highest priority
//   bus : seg_scan_ctrl_if slave modport (en, cathod, lz_en, digits in;
//         seg, an, frame_done out)
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int N_DIGITS    = 2,
    parameter int PRESCALE    = 4,
    parameter int BLANK_TICKS = 1,
    parameter int ON_TICKS    = 4
) (
    input  logic             clk,
    input  logic             rst,
    seg_scan_ctrl_if.slave   bus
);
    localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int T_MAX = (BLANK_TICKS > ON_TICKS) ? BLANK_TICKS : ON_TICKS;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int IW    = $clog2(N_DIGITS);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t              state_q;
    logic [PW-1:0]       pre_cnt_q;
    logic [TW-1:0]       t_cnt_q;
    logic [IW-1:0]       idx_q;
    logic [6:0]          seg_l_q;
    logic [N_DIGITS-1:0] an_l_q;
    logic                frame_done_q;

    logic                tick;
    logic [IW-1:0]       idx_d;
    logic [3:0]          nibble;
    logic                blank_digit;
    logic [6:0]          seg_d;
    logic [N_DIGITS-1:0] an_d;
    logic [N_DIGITS-1:0] upper_zero;

    // upper_zero[k]: digit k and every more significant digit are zero.
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_upper_zero
            assign upper_zero[gi] = ~|bus.digits[4*N_DIGITS-1:4*gi];
        end
    endgenerate

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b0111111;
            4'h1: hex7 = 7'b0000110;
            4'h2: hex7 = 7'b1011011;
            4'h3: hex7 = 7'b1001111;
            4'h4: hex7 = 7'b1100110;
            4'h5: hex7 = 7'b1101101;
            4'h6: hex7 = 7'b1111101;
            4'h7: hex7 = 7'b0000111;
            4'h8: hex7 = 7'b1111111;
            4'h9: hex7 = 7'b1101111;
            4'hA: hex7 = 7'b1110111;
            4'hB: hex7 = 7'b1111100;
            4'hC: hex7 = 7'b0111001;
            4'hD: hex7 = 7'b1011110;
            4'hE: hex7 = 7'b1111001;
            default: hex7 = 7'b1110001;
        endcase
    endfunction

    assign tick   = (pre_cnt_q == PW'(PRESCALE - 1));
    assign idx_d  = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    assign nibble = bus.digits[{idx_q, 2'b00} +: 4];

    // Digit 0 always shows, so a zero reading is never fully dark.
    assign blank_digit = bus.lz_en && (idx_q != '0) && upper_zero[idx_q];
    assign seg_d       = blank_digit ? 7'b0000000 : hex7(nibble);

    always_comb begin
        an_d        = '0;
        an_d[idx_q] = 1'b1;
    end

    // Single FSM process; seg_l/an_l only change at phase boundaries, which
    // is what makes the ON-slot contents a snapshot of digits.
    always_ff @(posedge clk) begin
        if (rst || !bus.en) begin
            state_q      <= ST_BLANK;
            pre_cnt_q    <= '0;
            t_cnt_q      <= '0;
            idx_q        <= '0;
            seg_l_q      <= '0;
            an_l_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            pre_cnt_q    <= tick ? '0 : pre_cnt_q + PW'(1);
            if (tick) begin
                case (state_q)
                    ST_BLANK: begin
                        if (t_cnt_q == TW'(BLANK_TICKS - 1)) begin
                            state_q <= ST_ON;
                            t_cnt_q <= '0;
                            seg_l_q <= seg_d;
                            an_l_q  <= an_d;
                        end else begin
                            t_cnt_q <= t_cnt_q + TW'(1);
                        end
                    end
                    ST_ON: begin
                        if (t_cnt_q == TW'(ON_TICKS - 1)) begin
                            state_q      <= ST_BLANK;
                            t_cnt_q      <= '0;
                            seg_l_q      <= '0;
                            an_l_q       <= '0;
                            idx_q        <= idx_d;
                            frame_done_q <= (idx_q == IW'(N_DIGITS - 1));
                        end else begin
                            t_cnt_q <= t_cnt_q + TW'(1);
                        end
                    end
                    default: state_q <= ST_BLANK;
                endcase
            end
        end
    end

    // Polarity is applied combinationally so a cathod change is immediate.
    assign bus.seg        = bus.cathod ? seg_l_q : ~seg_l_q;
    assign bus.an         = bus.cathod ? an_l_q  : ~an_l_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scheduler that shares the single 7-segment segment bus between `N_DIGITS` digit selects on the display board. It sits between the counter datapath (which supplies packed 4-bit digit values) and the pins `seg`/`an`. Each digit gets a fixed-length on slot, separated by a blanking dead-time to prevent ghosting. The block also provides hex decoding, leading-zero suppression, common-anode/common-cathode polarity selection and a frame-done pulse.

## Interface
- `N_DIGITS`, 2: number of digits scanned; must be ≥ 2.
- `PRESCALE`, 4: clock cycles per scan tick; must be ≥ 1.
- `BLANK_TICKS`, 1: ticks of all-off dead-time before each digit slot; must be ≥ 1.
- `ON_TICKS`, 4: ticks each digit is lit; must be ≥ 1.

- `clk` in 1: single clock. All state changes on its rising edge.
- `rst` in 1: reset. It is synchronous and active-high.
- `en` in 1: scan enable. While low, the block is held in its reset state.
- `cathod` in 1: polarity select. 0 = common-anode (segments and selects active-low); 1 = common-cathode (active-high).
- `lz_en` in 1: when 1, leading zeros are blanked.
- `digits` in 4*N_DIGITS: packed digit values. Digit k occupies `[4k+3:4k]`; digit 0 is least significant.
- `seg` out 7: physical segment drive, ordered {g,f,e,d,c,b,a}.
- `an` out N_DIGITS: physical digit selects. Bit k selects digit k.
- `frame_done` out 1: one-cycle pulse at the end of the last digit's on slot.

## Operation
- Internal logical signals `seg_l` and `an_l` use 1 = lit / selected. Both are registered.
- Physical outputs: `seg = cathod ? seg_l : ~seg_l`; `an = cathod ? an_l : ~an_l`. This inversion is combinational, so a change on `cathod` takes effect in the same cycle.
- Prescaler `pre_cnt` counts 0..PRESCALE-1 while `en` is high. `tick` = (`pre_cnt` == PRESCALE-1).
- Tick counter `t_cnt` counts ticks within the current phase.
- Digit index `idx` runs 0..N_DIGITS-1 and wraps to 0.
- States:
  - BLANK: `seg_l` = 0, `an_l` = 0. On the tick that completes BLANK_TICKS ticks, go to ON and clear `t_cnt`.
  - ON: `an_l` is one-hot at `idx`; `seg_l` holds the decoded snapshot. On the tick that completes ON_TICKS ticks, go to BLANK and set `idx` ← (`idx`+1) mod N_DIGITS.
- Snapshot: on the edge entering ON, latch `digits[4idx+3:4idx]` and load the decoded pattern into `seg_l`. `digits` changes during a slot have no effect until the next slot.
- Decode: 0–9 standard; 10–15 as hex A, b, C, d, E, F.
  - 0 = 7'b0111111, 1 = 7'b0000110, 8 = 7'b1111111, A = 7'b1110111, F = 7'b1110001.
- Leading-zero suppression, applied when `lz_en` = 1:
  - Digit k (k ≥ 1) is blanked (`seg_l` = 0, `an_l` still asserted) when digit k and every higher digit are 0.
  - Digit 0 is never blanked.
  - Evaluation uses the `digits` value at the snapshot edge.
- `frame_done`: registered, high for exactly one cycle on the edge where ON → BLANK with `idx` = N_DIGITS-1.
- Reset (`rst` = 1) or `en` = 0:
  - Next edge: state BLANK, `idx` = 0, `pre_cnt` = 0, `t_cnt` = 0, `seg_l` = 0, `an_l` = 0, `frame_done` = 0.
  - This holds for as long as the condition persists, including mid-slot.
  - `rst` has priority over everything.
- Physical reset values: with `cathod` = 0, `seg` = 7'h7F and `an` = all ones; with `cathod` = 1, both are all zeros.

## Timing
- Edge numbering: edge 1 is the first rising edge with `rst` = 0 and `en` = 1.
- First tick occurs at edge PRESCALE. Ticks then repeat every PRESCALE cycles.
- Digit 0 lights at edge BLANK_TICKS·PRESCALE. With defaults: edge 4.
- Slot length: ON_TICKS·PRESCALE cycles lit (defaults: 16), followed by BLANK_TICKS·PRESCALE cycles dark (defaults: 4).
- Frame period: N_DIGITS·(BLANK_TICKS+ON_TICKS)·PRESCALE cycles. Defaults: 40.
- With defaults, `frame_done` is high on edge 40, then on edge 80, and so on.
- At most one `an_l` bit is ever set. Between any two different selects there are always ≥ BLANK_TICKS·PRESCALE all-off cycles.

## Test plan
- Reset and polarity:
  - Stimulus: `rst` = 1 for 3 cycles with `cathod` = 0.
  - Required: `seg` = 7'h7F and `an` = 2'b11.
  - Then toggle `cathod` to 1. Required: `seg` = 0 and `an` = 0 in the same cycle.
- Scan order, defaults:
  - Stimulus: `digits` = 8'h42, `lz_en` = 0, `cathod` = 1.
  - Required: edges 4–19 show `an` = 2'b01 with the pattern for 2 (7'b1011011); edges 20–23 show `an` = 0; edges 24–39 show `an` = 2'b10 with the pattern for 4 (7'b1100110).
  - Required: `frame_done` is a single-cycle pulse at edge 40.
- Leading-zero suppression:
  - Stimulus: `digits` = 8'h07, `lz_en` = 1.
  - Required: during the digit-1 slot, `an` = 2'b10 and `seg_l` = 0. The digit-0 slot shows 7.
  - Stimulus: `digits` = 8'h00. Required: digit 0 shows 0 (7'b0111111).
- Snapshot stability:
  - Stimulus: change `digits` from 8'h11 to 8'h99 mid-slot of digit 0.
  - Required: `seg` holds the pattern for 1 until that slot ends. The digit-1 slot then shows 9.
- Enable and reset mid-slot:
  - Stimulus: drop `en` at edge 10.
  - Required: from edge 11, outputs are off and `idx` = 0.
  - Stimulus: reassert `en`. Required: digit 0 relights exactly 4 cycles later.
  - Same check with `rst` pulsed mid-slot.
- Hex decode:
  - Stimulus: sweep digit 0 through values 0–F.
  - Required: each value matches the decode patterns. An assertion checks `an_l` is one-hot-or-zero throughout.
